// File: rtl/csc_pkg.sv
// Shared types and helpers for the colour space converter pixel ingress stage.
package csc_pkg;

    localparam int unsigned CH_W_DEF   = 8;
    localparam int unsigned NUM_CH_DEF = 3;

    // Frame markers carried alongside each pixel through the FIFO.
    typedef struct packed {
        logic sof;
        logic eol;
    } tag_t;

    // Index width for a power-of-two depth; never below one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/csc_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module csc_sync_fifo
    import csc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = addr_w(DEPTH),
    localparam int unsigned PW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW-1:0]    level_o
);

    localparam logic [PW-1:0] FullXor = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q ^ rd_ptr_q) == FullXor;
    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign level_o = wr_ptr_q - rd_ptr_q;

    // Head entry drives the output directly; no bypass from the write port.
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/csc_pixel_ingress.sv
// Pixel input stage for the colour space converter: packs pixel plus frame tags
// into a FWFT FIFO, exposes ready backpressure and counts pixels dropped when full.
module csc_pixel_ingress
    import csc_pkg::*;
#(
    parameter int unsigned CH_W   = CH_W_DEF,
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned PIX_W = NUM_CH * CH_W,
    localparam int unsigned LVL_W = addr_w(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             data_valid_i,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             sof_i,
    input  logic             eol_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [PIX_W-1:0] pix_o,
    output logic             sof_o,
    output logic             eol_o,
    input  logic             ready_i,
    output logic [LVL_W-1:0] level_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    input  logic             clr_err_i
);

    localparam int unsigned ENT_W = PIX_W + $bits(tag_t);
    localparam logic [CNT_W-1:0] CntMax = '1;

    tag_t             in_tag, out_tag;
    logic [ENT_W-1:0] wdata, rdata;
    logic             full, empty;
    logic             push, pop, drop;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign in_tag = '{sof: sof_i, eol: eol_i};
    assign wdata  = {in_tag, pix_i};

    // ready_o depends only on registered pointers, never on this cycle's inputs.
    assign ready_o = ~full;
    assign valid_o = ~empty;

    assign push = data_valid_i & ready_o;
    assign pop  = valid_o & ready_i;
    assign drop = data_valid_i & ~ready_o;

    csc_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    assign out_tag = tag_t'(rdata[ENT_W-1 -: $bits(tag_t)]);
    assign pix_o   = rdata[PIX_W-1:0];
    assign sof_o   = out_tag.sof;
    assign eol_o   = out_tag.eol;

    // A drop coinciding with a clear survives it as a fresh single event.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_err_i) begin
            overflow_d = drop;
            drop_cnt_d = CNT_W'(drop);
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CntMax) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_csc_pixel_ingress.sv
// Self-checking bench for csc_pixel_ingress: a 3x8-bit instance with a 4-bit drop
// counter for directed tests, and a 4x10-bit instance for a randomised stream.
module tb_csc_pixel_ingress;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned A_PW   = 24;
    localparam int unsigned A_CNTW = 4;
    localparam int unsigned B_PW   = 40;
    localparam int unsigned B_CNTW = 16;
    localparam int unsigned LVL_W  = 4;
    localparam int unsigned A_MAX  = 15;
    localparam int unsigned B_MAX  = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CH_W 8, NUM_CH 3, CNT_W 4
    logic              rst_a, dv_a, sof_a, eol_a, rdy_a, clr_a;
    logic [A_PW-1:0]   pix_a, pix_o_a;
    logic              ready_a, valid_a, sof_o_a, eol_o_a, ovf_a;
    logic [LVL_W-1:0]  level_a;
    logic [A_CNTW-1:0] cnt_a;

    // Instance B: CH_W 10, NUM_CH 4, CNT_W 16
    logic              rst_b, dv_b, sof_b, eol_b, rdy_b, clr_b;
    logic [B_PW-1:0]   pix_b, pix_o_b;
    logic              ready_b, valid_b, sof_o_b, eol_o_b, ovf_b;
    logic [LVL_W-1:0]  level_b;
    logic [B_CNTW-1:0] cnt_b;

    csc_pixel_ingress #(
        .CH_W (8), .NUM_CH (3), .DEPTH (DEPTH), .CNT_W (A_CNTW)
    ) u_dut_a (
        .clk (clk), .rst_i (rst_a), .data_valid_i (dv_a), .pix_i (pix_a),
        .sof_i (sof_a), .eol_i (eol_a), .ready_o (ready_a), .valid_o (valid_a),
        .pix_o (pix_o_a), .sof_o (sof_o_a), .eol_o (eol_o_a), .ready_i (rdy_a),
        .level_o (level_a), .overflow_o (ovf_a), .drop_cnt_o (cnt_a), .clr_err_i (clr_a)
    );

    csc_pixel_ingress #(
        .CH_W (10), .NUM_CH (4), .DEPTH (DEPTH), .CNT_W (B_CNTW)
    ) u_dut_b (
        .clk (clk), .rst_i (rst_b), .data_valid_i (dv_b), .pix_i (pix_b),
        .sof_i (sof_b), .eol_i (eol_b), .ready_o (ready_b), .valid_o (valid_b),
        .pix_o (pix_o_b), .sof_o (sof_o_b), .eol_o (eol_o_b), .ready_i (rdy_b),
        .level_o (level_b), .overflow_o (ovf_b), .drop_cnt_o (cnt_b), .clr_err_i (clr_b)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Scoreboards hold {sof, eol, pix} of accepted pixels in arrival order.
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    bit          m_ovf_a, m_ovf_b;
    int unsigned m_cnt_a, m_cnt_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string ctx);
        chk({ctx, ".level_a"}, 64'(level_a), 64'(q_a.size()));
        chk({ctx, ".ready_a"}, 64'(ready_a), 64'(q_a.size() < DEPTH));
        chk({ctx, ".valid_a"}, 64'(valid_a), 64'(q_a.size() != 0));
        if (q_a.size() != 0) chk({ctx, ".head_a"}, 64'({sof_o_a, eol_o_a, pix_o_a}), q_a[0]);
        chk({ctx, ".ovf_a"}, 64'(ovf_a), 64'(m_ovf_a));
        chk({ctx, ".cnt_a"}, 64'(cnt_a), 64'(m_cnt_a));
    endtask

    task automatic check_b(input string ctx);
        chk({ctx, ".level_b"}, 64'(level_b), 64'(q_b.size()));
        chk({ctx, ".ready_b"}, 64'(ready_b), 64'(q_b.size() < DEPTH));
        chk({ctx, ".valid_b"}, 64'(valid_b), 64'(q_b.size() != 0));
        if (q_b.size() != 0) chk({ctx, ".head_b"}, 64'({sof_o_b, eol_o_b, pix_o_b}), q_b[0]);
        chk({ctx, ".ovf_b"}, 64'(ovf_b), 64'(m_ovf_b));
        chk({ctx, ".cnt_b"}, 64'(cnt_b), 64'(m_cnt_b));
    endtask

    // Check current outputs, clock once, then advance the model with the inputs just applied.
    task automatic cyc_a(input string ctx);
        bit p, o, d;
        check_a(ctx);
        p = dv_a && (q_a.size() < DEPTH);
        d = dv_a && (q_a.size() >= DEPTH);
        o = rdy_a && (q_a.size() != 0);
        @(posedge clk);
        #1;
        if (o) void'(q_a.pop_front());
        if (p) q_a.push_back(64'({sof_a, eol_a, pix_a}));
        if (clr_a) begin
            m_ovf_a = d;
            m_cnt_a = d ? 1 : 0;
        end else if (d) begin
            m_ovf_a = 1'b1;
            if (m_cnt_a < A_MAX) m_cnt_a++;
        end
    endtask

    task automatic cyc_b(input string ctx);
        bit p, o, d;
        check_b(ctx);
        p = dv_b && (q_b.size() < DEPTH);
        d = dv_b && (q_b.size() >= DEPTH);
        o = rdy_b && (q_b.size() != 0);
        @(posedge clk);
        #1;
        if (o) void'(q_b.pop_front());
        if (p) q_b.push_back(64'({sof_b, eol_b, pix_b}));
        if (clr_b) begin
            m_ovf_b = d;
            m_cnt_b = d ? 1 : 0;
        end else if (d) begin
            m_ovf_b = 1'b1;
            if (m_cnt_b < B_MAX) m_cnt_b++;
        end
    endtask

    initial begin
        int unsigned acc;
        int unsigned guard;
        bit          will_push;

        rst_a = 1'b1; dv_a = 1'b0; sof_a = 1'b0; eol_a = 1'b0; rdy_a = 1'b0; clr_a = 1'b0;
        pix_a = '0;
        rst_b = 1'b1; dv_b = 1'b0; sof_b = 1'b0; eol_b = 1'b0; rdy_b = 1'b0; clr_b = 1'b0;
        pix_b = '0;
        m_ovf_a = 1'b0; m_cnt_a = 0; m_ovf_b = 1'b0; m_cnt_b = 0;
        #12;
        check_a("rst_held");
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check_a("rst");
        check_b("rst");

        // 1: three pixels through an always-ready sink
        rdy_a = 1'b1;
        dv_a = 1'b1; pix_a = 24'h112233; sof_a = 1'b1; cyc_a("t1.p0");
        pix_a = 24'h445566; sof_a = 1'b0; cyc_a("t1.p1");
        pix_a = 24'h778899; eol_a = 1'b1; cyc_a("t1.p2");
        dv_a = 1'b0; eol_a = 1'b0; cyc_a("t1.d0");
        cyc_a("t1.d1");

        // 2: fill with the sink stalled, then one pixel from a source ignoring ready
        rdy_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dv_a = 1'b1; pix_a = 24'hA00000 + 24'(i); sof_a = (i == 0); eol_a = (i == 7);
            cyc_a("t2.fill");
        end
        pix_a = 24'h0BAD00; sof_a = 1'b0; eol_a = 1'b0; cyc_a("t2.drop");
        dv_a = 1'b0; cyc_a("t2.hold");

        // 3: pop and attempted push together while full
        rdy_a = 1'b1; dv_a = 1'b1; pix_a = 24'hC0FFEE; cyc_a("t3.both");
        rdy_a = 1'b0; dv_a = 1'b0; cyc_a("t3.after");

        // 4: refill, then saturate the 4-bit drop counter and clear with a coincident drop
        dv_a = 1'b1; pix_a = 24'hD00D00;
        for (int i = 0; i < 21; i++) cyc_a("t4.sat");
        clr_a = 1'b1; cyc_a("t4.clr_drop");
        clr_a = 1'b0; dv_a = 1'b0; cyc_a("t4.post");
        clr_a = 1'b1; cyc_a("t4.clr");
        clr_a = 1'b0; cyc_a("t4.clr_done");
        rdy_a = 1'b1;
        for (int i = 0; i < 10; i++) cyc_a("t4.drain");

        // 6: asynchronous reset mid-burst at level 5
        rdy_a = 1'b0; dv_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pix_a = 24'hE00000 + 24'(i); cyc_a("t6.fill");
        end
        dv_a = 1'b0; cyc_a("t6.lvl5");
        #3;
        rst_a = 1'b1;
        #1;
        q_a.delete();
        m_ovf_a = 1'b0; m_cnt_a = 0;
        check_a("t6.async");
        #2;
        rst_a = 1'b0;
        rdy_a = 1'b1; dv_a = 1'b1; pix_a = 24'h5A5A5A; sof_a = 1'b1; cyc_a("t6.new");
        dv_a = 1'b0; sof_a = 1'b0; cyc_a("t6.out");
        cyc_a("t6.idle");

        // 5: 100 random pixels against random sink readiness, wrapping the pointers
        acc = 0;
        guard = 0;
        dv_b = 1'b1;
        pix_b = B_PW'({$urandom(), $urandom()}); sof_b = 1'b1; eol_b = 1'b0;
        while (acc < 100 && guard < 3000) begin
            rdy_b = 1'($urandom_range(0, 1));
            will_push = q_b.size() < DEPTH;
            cyc_b("t5.stream");
            if (will_push) begin
                acc++;
                pix_b = B_PW'({$urandom(), $urandom()});
                sof_b = (acc % 10) == 0;
                eol_b = (acc % 10) == 9;
            end
            guard++;
        end
        dv_b = 1'b0; rdy_b = 1'b1;
        guard = 0;
        while (q_b.size() != 0 && guard < 50) begin
            cyc_b("t5.drain");
            guard++;
        end
        cyc_b("t5.empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
